// File: rtl/n_stage_valid_pipe.sv
// Parametrised valid/ready delay line carrying payload and destination info,
// with per-stage flush, optional bubble collapse and RAW/WAW query ports.
module n_stage_valid_pipe #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned RD_W     = 5,
    parameter int unsigned COLLAPSE = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  logic [WIDTH-1:0]               data_i,
    input  logic [RD_W-1:0]                rd_i,
    input  logic                           wr_i,
    input  logic                           fp_wr_i,
    input  logic [DEPTH-1:0]               clr,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [WIDTH-1:0]               data_o,
    output logic [RD_W-1:0]                rd_o,
    output logic                           wr_o,
    output logic                           fp_wr_o,
    output logic [DEPTH-1:0]               stage_valid_o,
    output logic [DEPTH*RD_W-1:0]          stage_rd_o,
    output logic [DEPTH-1:0]               stage_wr_o,
    output logic [DEPTH-1:0]               stage_fp_wr_o,
    input  logic [3*RD_W-1:0]              q_rs,
    input  logic [2:0]                     q_fp,
    output logic [2:0]                     q_hit_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] wr_q;
    logic [DEPTH-1:0] fp_q;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [RD_W-1:0]  rd_q   [DEPTH];
    logic             fire;
    logic             adv_chain;

    assign live    = v & ~clr;
    assign valid_o = live[DEPTH-1];
    assign fire    = valid_o & ready_i;
    assign ready_o = adv[0];

    // adv[k] means stage k may load from k-1: it is empty or its entry moves on.
    always_comb begin
        adv       = '0;
        adv_chain = fire | ~live[DEPTH-1];
        adv[DEPTH-1] = adv_chain;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (COLLAPSE != 0) begin
                adv_chain = ~live[DEPTH-1-i] | adv_chain;
            end
            adv[DEPTH-1-i] = adv_chain;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v    <= '0;
            wr_q <= '0;
            fp_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                rd_q[i]   <= '0;
            end
        end else begin
            if (adv[0]) begin
                v[0]      <= valid_i;
                data_q[0] <= data_i;
                rd_q[0]   <= rd_i;
                wr_q[0]   <= wr_i;
                fp_q[0]   <= fp_wr_i;
            end else begin
                v[0] <= live[0];
            end
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (adv[i]) begin
                    v[i]      <= live[i-1];
                    data_q[i] <= data_q[i-1];
                    rd_q[i]   <= rd_q[i-1];
                    wr_q[i]   <= wr_q[i-1];
                    fp_q[i]   <= fp_q[i-1];
                end else begin
                    v[i] <= live[i];
                end
            end
        end
    end

    assign data_o        = data_q[DEPTH-1];
    assign rd_o          = rd_q[DEPTH-1];
    assign wr_o          = wr_q[DEPTH-1] & valid_o;
    assign fp_wr_o       = fp_q[DEPTH-1] & valid_o;
    assign stage_valid_o = live;
    assign stage_wr_o    = wr_q & live;
    assign stage_fp_wr_o = fp_q & live;

    always_comb begin
        stage_rd_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_rd_o[i*RD_W +: RD_W] = rd_q[i];
        end
    end

    // Integer x0 is never a hazard; FP register 0 is a real register.
    always_comb begin
        q_hit_o = '0;
        for (int unsigned j = 0; j < 3; j++) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (live[k] && (rd_q[k] == q_rs[j*RD_W +: RD_W])) begin
                    if (q_fp[j] ? fp_q[k] : (wr_q[k] && (rd_q[k] != '0))) begin
                        q_hit_o[j] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        count_o = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            count_o = count_o + CW'(live[k]);
        end
    end

endmodule

// File: tb/tb_n_stage_valid_pipe.sv
// Randomised scoreboard bench for n_stage_valid_pipe, running a collapsing
// instance (index 0) and a lockstep instance (index 1) on shared stimulus.
module tb_n_stage_valid_pipe;

    localparam int D    = 3;
    localparam int W    = 32;
    localparam int R    = 5;
    localparam int CW   = 2;
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic           valid_i, wr_i, fp_wr_i, ready_i;
    logic [W-1:0]   data_i;
    logic [R-1:0]   rd_i;
    logic [D-1:0]   clr;
    logic [3*R-1:0] q_rs;
    logic [2:0]     q_fp;

    logic [1:0]     rdy, vo, wro, fpo;
    logic [W-1:0]   dout [2];
    logic [R-1:0]   rdo  [2];
    logic [D-1:0]   sv   [2];
    logic [D-1:0]   swr  [2];
    logic [D-1:0]   sfp  [2];
    logic [D*R-1:0] srd  [2];
    logic [2:0]     hit  [2];
    logic [CW-1:0]  cnt  [2];

    n_stage_valid_pipe #(.WIDTH(W), .DEPTH(D), .RD_W(R), .COLLAPSE(1)) u_collapse (
        .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(rdy[0]),
        .data_i(data_i), .rd_i(rd_i), .wr_i(wr_i), .fp_wr_i(fp_wr_i), .clr(clr),
        .valid_o(vo[0]), .ready_i(ready_i), .data_o(dout[0]), .rd_o(rdo[0]),
        .wr_o(wro[0]), .fp_wr_o(fpo[0]), .stage_valid_o(sv[0]), .stage_rd_o(srd[0]),
        .stage_wr_o(swr[0]), .stage_fp_wr_o(sfp[0]), .q_rs(q_rs), .q_fp(q_fp),
        .q_hit_o(hit[0]), .count_o(cnt[0])
    );

    n_stage_valid_pipe #(.WIDTH(W), .DEPTH(D), .RD_W(R), .COLLAPSE(0)) u_lockstep (
        .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(rdy[1]),
        .data_i(data_i), .rd_i(rd_i), .wr_i(wr_i), .fp_wr_i(fp_wr_i), .clr(clr),
        .valid_o(vo[1]), .ready_i(ready_i), .data_o(dout[1]), .rd_o(rdo[1]),
        .wr_o(wro[1]), .fp_wr_o(fpo[1]), .stage_valid_o(sv[1]), .stage_rd_o(srd[1]),
        .stage_wr_o(swr[1]), .stage_fp_wr_o(sfp[1]), .q_rs(q_rs), .q_fp(q_fp),
        .q_hit_o(hit[1]), .count_o(cnt[1])
    );

    typedef struct packed {
        logic [W-1:0] data;
        logic [R-1:0] rd;
        logic         wr;
        logic         fp;
    } ent_t;

    typedef struct {
        ent_t        e;
        int unsigned sn;
    } sb_t;

    // Reference: slot occupancy per instance, plus the in-order expected output stream.
    bit          mv [2][D];
    ent_t        me [2][D];
    int unsigned ms [2][D];
    sb_t         sbq [2][$];
    bit          killed [2][8192];
    int unsigned nsn [2];

    int checks   = 0;
    int failures = 0;

    task automatic check(input int i, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL inst%0d %s got=%0h want=%0h at %0t", i, nm, act, exp, $time);
        end
    endtask

    function automatic logic [R-1:0] pick_rd();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd7;
            2: return 5'd9;
            default: return R'($urandom);
        endcase
    endfunction

    task automatic check_comb(input int i);
        bit lv [D];
        bit any_hole;
        bit fire;
        int n;
        logic [2:0]   h;
        logic [D-1:0] lvv, ewr, efp;
        n = 0; any_hole = 0; h = '0; lvv = '0; ewr = '0; efp = '0;
        for (int k = 0; k < D; k++) begin
            lv[k]  = mv[i][k] && !clr[k];
            lvv[k] = lv[k];
            ewr[k] = lv[k] && me[i][k].wr;
            efp[k] = lv[k] && me[i][k].fp;
            if (lv[k]) n++;
            else any_hole = 1;
        end
        fire = lv[D-1] && ready_i;
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < D; k++)
                if (lv[k] && me[i][k].rd == q_rs[j*R +: R] &&
                    (q_fp[j] ? me[i][k].fp : (me[i][k].wr && me[i][k].rd != 0)))
                    h[j] = 1'b1;
        check(i, "ready_o", 64'(rdy[i]), 64'((i == 0) ? (fire || any_hole) : (fire || !lv[D-1])));
        check(i, "valid_o", 64'(vo[i]), 64'(lv[D-1]));
        check(i, "stage_valid_o", 64'(sv[i]), 64'(lvv));
        check(i, "count_o", 64'(cnt[i]), 64'(n));
        check(i, "q_hit_o", 64'(hit[i]), 64'(h));
        check(i, "stage_wr_o", 64'(swr[i]), 64'(ewr));
        check(i, "stage_fp_wr_o", 64'(sfp[i]), 64'(efp));
        check(i, "wr_o", 64'(wro[i]), 64'(ewr[D-1]));
        check(i, "fp_wr_o", 64'(fpo[i]), 64'(efp[D-1]));
        for (int k = 0; k < D; k++)
            if (lv[k]) check(i, "stage_rd_o", 64'(srd[i][k*R +: R]), 64'(me[i][k].rd));
    endtask

    // Slot k is refilled when a free slot exists at or ahead of k (collapsing),
    // or when the last slot empties (lockstep); entries keep their order.
    task automatic step(input int i);
        bit lv [D];
        bit mov [D];
        bit nv [D];
        ent_t ne [D];
        int unsigned ns [D];
        bit fire, hole;
        for (int k = 0; k < D; k++) lv[k] = mv[i][k] && !clr[k];
        fire = lv[D-1] && ready_i;
        for (int k = 0; k < D; k++) begin
            hole = 0;
            for (int j = k; j < D; j++) if (!lv[j]) hole = 1;
            mov[k] = (i == 0) ? (fire || hole) : (fire || !lv[D-1]);
            if (mv[i][k] && clr[k]) killed[i][ms[i][k]] = 1;
        end
        for (int k = D-1; k >= 1; k--) begin
            if (mov[k]) begin nv[k] = lv[k-1]; ne[k] = me[i][k-1]; ns[k] = ms[i][k-1]; end
            else        begin nv[k] = lv[k];   ne[k] = me[i][k];   ns[k] = ms[i][k];   end
        end
        if (mov[0]) begin
            nv[0] = valid_i;
            ne[0] = {data_i, rd_i, wr_i, fp_wr_i};
            ns[0] = nsn[i];
            if (valid_i) begin
                sbq[i].push_back('{e: ne[0], sn: nsn[i]});
                nsn[i]++;
            end
        end else begin
            nv[0] = lv[0]; ne[0] = me[i][0]; ns[0] = ms[i][0];
        end
        for (int k = 0; k < D; k++) begin
            mv[i][k] = nv[k]; me[i][k] = ne[k]; ms[i][k] = ns[k];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < D; k++) mv[i][k] = 0;
            sbq[i].delete();
        end
    endtask

    // Monitor: every output handshake must match the oldest surviving entry.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset_n && vo[i] && ready_i) begin
                sb_t s;
                while (sbq[i].size() > 0 && killed[i][sbq[i][0].sn]) void'(sbq[i].pop_front());
                if (sbq[i].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL inst%0d unexpected_output got=%0h want=none", i, dout[i]);
                end else begin
                    s = sbq[i].pop_front();
                    check(i, "data_o", 64'(dout[i]), 64'(s.e.data));
                    check(i, "rd_o", 64'(rdo[i]), 64'(s.e.rd));
                    check(i, "wr_o_fire", 64'(wro[i]), 64'(s.e.wr));
                    check(i, "fp_wr_o_fire", 64'(fpo[i]), 64'(s.e.fp));
                end
            end
        end
    end

    initial begin
        valid_i = 0; wr_i = 0; fp_wr_i = 0; ready_i = 0;
        data_i = '0; rd_i = '0; clr = '0; q_rs = '0; q_fp = '0;
        repeat (2) @(negedge clk);
        check_comb(0);
        check_comb(1);
        reset_n = 1'b1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            valid_i = ($urandom_range(0, 9) < 7);
            ready_i = ((cyc % 200) < 40) ? 1'b0 : ($urandom_range(0, 9) < 6);
            data_i  = $urandom;
            rd_i    = pick_rd();
            wr_i    = $urandom_range(0, 1);
            fp_wr_i = $urandom_range(0, 1);
            for (int k = 0; k < D; k++) clr[k] = ($urandom_range(0, 15) == 0);
            for (int j = 0; j < 3; j++) q_rs[j*R +: R] = pick_rd();
            q_fp = 3'($urandom);
            @(negedge clk);
            check_comb(0);
            check_comb(1);
            step(0);
            step(1);
            if (cyc == 1500 || cyc == 2500) begin
                #1 reset_n = 1'b0;
                #1;
                model_reset();
                check_comb(0);
                check_comb(1);
                step(0);
                step(1);
                #1 reset_n = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        valid_i = 0; ready_i = 1; clr = '0;
        for (int c = 0; c < D + 4; c++) begin
            @(negedge clk);
            check_comb(0);
            check_comb(1);
            step(0);
            step(1);
        end
        for (int i = 0; i < 2; i++) begin
            while (sbq[i].size() > 0 && killed[i][sbq[i][0].sn]) void'(sbq[i].pop_front());
            check(i, "drained_left", 64'(sbq[i].size()), 64'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
